// File: rtl/shift_sub_divider.sv
// Restoring shift/subtract unsigned divider with a valid/ready handshake on both sides.
// Define CT_TIME_EN to make every operation take WIDTH iterations regardless of operands.
module shift_sub_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] qsr;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt;
  logic             dbz;
  logic             fast;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             q_bit;

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // One extra bit keeps the shifted remainder exact even when b uses the MSB.
  assign rem_shift = {rem, qsr[WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, b_reg});
  assign rem_sub   = rem_shift - {1'b0, b_reg};

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)              state_nxt = BUSY;
      BUSY: if (fast || last_step)   state_nxt = DONE;
      DONE: if (out_ready)           state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qsr   <= '0;
      rem   <= '0;
      b_reg <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      if (accept) begin
        qsr   <= a;
        rem   <= '0;
        b_reg <= b;
        cnt   <= '0;
        dbz   <= (b == '0);
      end else if (state == BUSY) begin
        if (fast) begin
          // Trivial operands: quotient is all ones (b==0) or zero (a<b); remainder is a.
          qsr <= dbz ? '1 : '0;
          rem <= qsr;
        end else begin
          qsr <= {qsr[WIDTH-2:0], q_bit};
          rem <= q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef CT_TIME_EN
  assign fast = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fast <= 1'b0;
    else if (accept) fast <= (b == '0) || (a < b);
  end
`endif

  assign in_ready    = (state == IDLE);
  assign busy        = (state == BUSY);
  assign out_valid   = (state == DONE);
  assign q           = out_valid ? qsr : '0;
  assign r           = out_valid ? rem : '0;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider (WIDTH=8): directed cases plus random
// operands against an arithmetic reference model; honours CT_TIME_EN for latency.
module tb_shift_sub_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q, r;
  logic         div_by_zero;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer division with the divide-by-zero convention.
  function automatic void model(input int ua, input int ub, output int eq, output int er,
                                output int elat);
    if (ub == 0) begin eq = (1 << W) - 1; er = ua; end
    else         begin eq = ua / ub;      er = ua % ub; end
`ifdef CT_TIME_EN
    elat = W;
`else
    elat = (ub == 0 || ua < ub) ? 1 : W;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, hold the result for 'hold' cycles, then hand it off.
  task automatic do_op(input int ua, input int ub, input int hold, input bit full);
    int eq, er, elat, lat;
    logic [W-1:0] q_seen, r_seen;
    model(ua, ub, eq, er, elat);
    check("in_ready_before", in_ready, 1);
    in_valid  = 1'b1;
    a         = W'(ua);
    b         = W'(ub);
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    if (full) check("in_ready_after_accept", in_ready, 0);
    lat = 0;
    do begin
      if (full && elat == W && lat > 0) check("busy_mid", busy, 1);
      tick();
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", lat, elat);
    check("q", q, eq);
    check("r", r, er);
    check("dbz", div_by_zero, (ub == 0));
    q_seen = q;
    r_seen = r;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_q", q, q_seen);
      check("hold_r", r, r_seen);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (hold > 0) tick();
    if (hold == 0) tick();
    check("valid_after_handoff", out_valid, 0);
    check("in_ready_after_handoff", in_ready, 1);
    if (full) begin
      check("q_idle", q, 0);
      check("r_idle", r, 0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int ua, ub;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;  // just past the next rising edge is too late; first accept below uses the first edge

    do_op(100, 7, 0, 1'b1);
    do_op(5, 0, 0, 1'b1);
    do_op(3, 9, 0, 1'b1);
    do_op(200, 13, 0, 1'b1);
    do_op(255, 1, 5, 1'b1);
    do_op(0, 255, 1, 1'b1);
    do_op(255, 255, 0, 1'b1);
    do_op(254, 255, 0, 1'b1);
    do_op(255, 128, 2, 1'b1);

    // Reset in the middle of an iteration.
    in_valid = 1'b1; a = 8'd100; b = 8'd7; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_dbz", div_by_zero, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    do_op(9, 3, 0, 1'b1);

    for (int n = 0; n < 2000; n++) begin
      ua = int'($urandom_range(0, 255));
      ub = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      do_op(ua, ub, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
